// File: rtl/locked_reg_pkg.sv
// locked_reg_pkg: shared reject-reason encoding and write-enable rule for the locked register bank
package locked_reg_pkg;
  typedef enum logic [1:0] {ERR_NONE, ERR_LOCKED, ERR_SCAN, ERR_RANGE} err_e;
  function automatic logic wr_ok(input logic locked, input logic scan, input logic dbg, input logic mask);
    return !scan && (!locked || (mask && dbg));
  endfunction
endpackage

// File: rtl/locked_reg_cell.sv
// locked_reg_cell: one bank entry with a sticky lock flop and a guarded data register
module locked_reg_cell
  import locked_reg_pkg::*;
#(
  parameter int                DATA_W    = 16,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter bit                DBG_EN    = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_sel,
  input  logic              i_lock_req,
  input  logic              i_scan,
  input  logic              i_dbg,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_we,
  output logic              o_locked,
  output logic [DATA_W-1:0] o_data
);
  logic              r_lock;
  logic [DATA_W-1:0] r_data;
  logic              w_lock_eff;
  // a same-cycle lock request already counts as locked, so it beats a concurrent write
  assign w_lock_eff = r_lock | i_lock_req;
  assign o_we       = i_sel && wr_ok(w_lock_eff, i_scan, i_dbg, DBG_EN);
  assign o_locked   = r_lock;
  assign o_data     = r_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_lock <= 1'b0;
      r_data <= RESET_VAL;
    end else begin
      r_lock <= w_lock_eff;
      if (o_we) r_data <= i_data;
    end
endmodule

// File: rtl/locked_register_bank.sv
// locked_register_bank: bank of lockable config registers; rejected writes pulse write_err and
// bump a saturating violation counter
module locked_register_bank
  import locked_reg_pkg::*;
#(
  parameter int                  DATA_W    = 16,
  parameter int                  NUM_REGS  = 4,
  parameter int                  ADDR_W    = 2,
  parameter logic [DATA_W-1:0]   RESET_VAL = '0,
  parameter logic [NUM_REGS-1:0] DBG_MASK  = '0,
  parameter int                  CNT_W     = 8
) (
  input  logic                Clk,
  input  logic                resetn,
  input  logic                write,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   Data_in,
  input  logic [NUM_REGS-1:0] Lock,
  input  logic                scan_mode,
  input  logic                debug_unlocked,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   Data_out,
  output logic [NUM_REGS-1:0] lock_status,
  output logic                write_err,
  output logic [CNT_W-1:0]    viol_count
);
  logic [NUM_REGS-1:0] w_sel, w_we;
  logic [DATA_W-1:0]   w_q [NUM_REGS];
  logic [DATA_W-1:0]   w_rd;
  logic                w_reject;
  err_e                w_reason;
  logic [DATA_W-1:0]   r_dout;
  logic                r_err;
  logic [CNT_W-1:0]    r_cnt;
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
    assign w_sel[i] = write && (wr_addr == ADDR_W'(i));
    locked_reg_cell #(
      .DATA_W   (DATA_W),
      .RESET_VAL(RESET_VAL),
      .DBG_EN   (DBG_MASK[i])
    ) u_cell (
      .clk       (Clk),
      .rst_n     (resetn),
      .i_sel     (w_sel[i]),
      .i_lock_req(Lock[i]),
      .i_scan    (scan_mode),
      .i_dbg     (debug_unlocked),
      .i_data    (Data_in),
      .o_we      (w_we[i]),
      .o_locked  (lock_status[i]),
      .o_data    (w_q[i])
    );
  end
  // no selected cell means the address is outside the bank
  assign w_reason = !write         ? ERR_NONE  :
                    !(|w_sel)      ? ERR_RANGE :
                    scan_mode      ? ERR_SCAN  :
                    !(|w_we)       ? ERR_LOCKED : ERR_NONE;
  assign w_reject = (w_reason != ERR_NONE);
  always_comb begin
    w_rd = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (rd_addr == ADDR_W'(k)) w_rd = w_q[k];
  end
  always_ff @(posedge Clk or negedge resetn)
    if (!resetn) begin
      r_dout <= RESET_VAL;
      r_err  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_dout <= w_rd;
      r_err  <= w_reject;
      if (w_reject && !(&r_cnt)) r_cnt <= r_cnt + CNT_W'(1);
    end
  always_ff @(posedge Clk)
    if (resetn) assert ($onehot0(w_we) && !(scan_mode && |w_we) && !(w_reject && |w_we));
  assign Data_out   = r_dout;
  assign write_err  = r_err;
  assign viol_count = r_cnt;
endmodule

// File: tb/tb_locked_register_bank.sv
// tb_locked_register_bank: directed checks of locking, debug override, scan blocking,
// counter saturation and async reset
module tb_locked_register_bank;
  logic        Clk = 1'b0;
  logic        resetn = 1'b1;
  logic        write = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [15:0] Data_in = '0;
  logic [3:0]  Lock = '0;
  logic        scan_mode = 1'b0;
  logic        debug_unlocked = 1'b0;
  logic [2:0]  rd_addr = '0;
  logic [15:0] Data_out;
  logic [3:0]  lock_status;
  logic        write_err;
  logic [1:0]  viol_count;
  int n_cmp = 0;
  int n_bad = 0;

  locked_register_bank #(
    .DATA_W(16), .NUM_REGS(4), .ADDR_W(3), .RESET_VAL(16'h0000),
    .DBG_MASK(4'b0010), .CNT_W(2)
  ) dut (
    .Clk(Clk), .resetn(resetn), .write(write), .wr_addr(wr_addr), .Data_in(Data_in),
    .Lock(Lock), .scan_mode(scan_mode), .debug_unlocked(debug_unlocked), .rd_addr(rd_addr),
    .Data_out(Data_out), .lock_status(lock_status), .write_err(write_err), .viol_count(viol_count)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #1 resetn = 1'b0;
    #1;
    chk("rst_dout", 32'(Data_out), 32'h0);
    chk("rst_lock", 32'(lock_status), 32'h0);
    chk("rst_err", 32'(write_err), 32'h0);
    chk("rst_cnt", 32'(viol_count), 32'h0);
    tick();
    resetn = 1'b1;
    write = 1'b1; wr_addr = 3'd1; Data_in = 16'hA5A5; rd_addr = 3'd1;
    tick();
    chk("t1_rdw_old", 32'(Data_out), 32'h0);
    chk("t1_err", 32'(write_err), 32'h0);
    write = 1'b0;
    tick();
    chk("t1_read", 32'(Data_out), 32'hA5A5);
    Lock = 4'b0010;
    tick();
    Lock = 4'b0000;
    chk("t2_lock", 32'(lock_status), 32'h2);
    write = 1'b1; Data_in = 16'h1234;
    tick();
    write = 1'b0;
    chk("t2_err", 32'(write_err), 32'h1);
    chk("t2_cnt", 32'(viol_count), 32'h1);
    tick();
    chk("t2_err_clr", 32'(write_err), 32'h0);
    chk("t2_keep", 32'(Data_out), 32'hA5A5);
    chk("t2_cnt_hold", 32'(viol_count), 32'h1);
    write = 1'b1; wr_addr = 3'd2; Data_in = 16'hBEEF; Lock = 4'b0100; rd_addr = 3'd2;
    tick();
    write = 1'b0; Lock = 4'b0000;
    chk("t3_err", 32'(write_err), 32'h1);
    chk("t3_lock", 32'(lock_status), 32'h6);
    chk("t3_cnt", 32'(viol_count), 32'h2);
    tick();
    chk("t3_keep", 32'(Data_out), 32'h0);
    Lock = 4'b1000;
    tick();
    Lock = 4'b0000;
    chk("t4_lock", 32'(lock_status), 32'hE);
    debug_unlocked = 1'b1; write = 1'b1; wr_addr = 3'd1; Data_in = 16'h5555;
    tick();
    chk("t4_dbg_ok", 32'(write_err), 32'h0);
    wr_addr = 3'd3;
    tick();
    write = 1'b0; debug_unlocked = 1'b0;
    chk("t4_dbg_rej", 32'(write_err), 32'h1);
    chk("t4_cnt", 32'(viol_count), 32'h3);
    rd_addr = 3'd1;
    tick();
    chk("t4_e1", 32'(Data_out), 32'h5555);
    rd_addr = 3'd3;
    tick();
    chk("t4_e3", 32'(Data_out), 32'h0);
    chk("t4_lock_kept", 32'(lock_status), 32'hE);
    rd_addr = 3'd1;
    tick();
    chk("t6_pre", 32'(Data_out), 32'h5555);
    Lock = 4'b0001; write = 1'b1; wr_addr = 3'd0; Data_in = 16'hFFFF;
    #2 resetn = 1'b0;
    #1;
    chk("t6_dout", 32'(Data_out), 32'h0);
    chk("t6_lock", 32'(lock_status), 32'h0);
    chk("t6_err", 32'(write_err), 32'h0);
    chk("t6_cnt", 32'(viol_count), 32'h0);
    tick();
    chk("t6_lock_held", 32'(lock_status), 32'h0);
    Lock = 4'b0000; write = 1'b0; resetn = 1'b1;
    write = 1'b1; wr_addr = 3'd1; Data_in = 16'h7777;
    tick();
    write = 1'b0;
    chk("t6_wr_err", 32'(write_err), 32'h0);
    tick();
    chk("t6_rewrite", 32'(Data_out), 32'h7777);
    scan_mode = 1'b1; write = 1'b1; wr_addr = 3'd0; Data_in = 16'h1111; Lock = 4'b0001;
    tick();
    Lock = 4'b0000;
    chk("t5_scan_err", 32'(write_err), 32'h1);
    chk("t5_cnt1", 32'(viol_count), 32'h1);
    chk("t5_scan_lock", 32'(lock_status), 32'h1);
    tick();
    chk("t5_cnt2", 32'(viol_count), 32'h2);
    scan_mode = 1'b0; wr_addr = 3'd5;
    tick();
    chk("t5_range_err", 32'(write_err), 32'h1);
    chk("t5_cnt3", 32'(viol_count), 32'h3);
    wr_addr = 3'd0;
    tick();
    chk("t5_sat4", 32'(viol_count), 32'h3);
    tick();
    write = 1'b0; rd_addr = 3'd0;
    chk("t5_sat5", 32'(viol_count), 32'h3);
    tick();
    chk("t5_idle_err", 32'(write_err), 32'h0);
    chk("t5_idle_cnt", 32'(viol_count), 32'h3);
    chk("t5_e0_keep", 32'(Data_out), 32'h0);
    rd_addr = 3'd1;
    tick();
    chk("t5_e1", 32'(Data_out), 32'h7777);
    rd_addr = 3'd5;
    tick();
    chk("t5_rd_range", 32'(Data_out), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
